// File: rtl/spi_burst_fsm.sv
// SPI slave transaction controller: header/data bit counting, read/write sequencing
// and optional auto-incrementing multi-word bursts under a single chip-select.
module spi_burst_fsm #(
  parameter int unsigned ADDR_BITS = 7,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BURST_EN  = 1,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs_pin,
  input  logic                         sclk_rise,
  input  logic                         rw,
  output logic                         shift_wren,
  output logic                         reset_counter,
  output logic                         addr_wren,
  output logic                         dm_wren,
  output logic                         miso_en,
  output logic                         addr_inc,
  output logic                         busy,
  output logic [$clog2(MAX_BURST)-1:0] burst_cnt
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST);
  localparam int unsigned CNT_W   = $clog2(ADDR_BITS + DATA_BITS + 1);

  typedef enum logic [3:0] {
    S_GET    = 4'd0,
    S_GOT    = 4'd1,
    S_READ1  = 4'd2,
    S_READ2  = 4'd3,
    S_WRITE1 = 4'd4,
    S_WRITE2 = 4'd5,
    S_INC    = 4'd6,
    S_DONE   = 4'd7
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 rw_q, rw_d;
  logic                 more_words;
  logic                 hdr_last;
  logic                 data_last;

  assign more_words = (BURST_EN != 0) && (burst_cnt_q < BURST_W'(MAX_BURST - 1));
  assign hdr_last   = sclk_rise && (bit_cnt_q == CNT_W'(ADDR_BITS));
  assign data_last  = sclk_rise && (bit_cnt_q == CNT_W'(DATA_BITS - 1));

  // Next-state logic; rises in one-cycle states count toward the following field.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    burst_cnt_d = burst_cnt_q;
    rw_d        = rw_q;
    if (sclk_rise) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    if (cs_pin) begin
      state_d     = S_GET;
      bit_cnt_d   = '0;
      burst_cnt_d = '0;
    end else begin
      case (state_q)
        S_GET: begin
          if (hdr_last) begin
            state_d   = S_GOT;
            bit_cnt_d = '0;
          end
        end
        S_GOT: begin
          rw_d    = rw;
          state_d = rw ? S_READ1 : S_WRITE1;
        end
        S_READ1: state_d = S_READ2;
        S_READ2: begin
          if (data_last) begin
            state_d   = more_words ? S_INC : S_DONE;
            bit_cnt_d = '0;
          end
        end
        S_WRITE1: begin
          if (data_last) begin
            state_d   = S_WRITE2;
            bit_cnt_d = '0;
          end
        end
        S_WRITE2: state_d = more_words ? S_INC : S_DONE;
        S_INC: begin
          if (burst_cnt_q != BURST_W'(MAX_BURST - 1)) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
          end
          state_d = rw_q ? S_READ1 : S_WRITE1;
        end
        S_DONE: bit_cnt_d = bit_cnt_q;
        default: begin
          state_d     = S_GET;
          bit_cnt_d   = '0;
          burst_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_GET;
      bit_cnt_q   <= '0;
      burst_cnt_q <= '0;
      rw_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rw_q        <= rw_d;
    end
  end

  // Moore decode; reset_counter in GET follows the live chip select.
  always_comb begin
    shift_wren    = 1'b0;
    reset_counter = 1'b0;
    addr_wren     = 1'b0;
    dm_wren       = 1'b0;
    miso_en       = 1'b0;
    addr_inc      = 1'b0;
    case (state_q)
      S_GET:    reset_counter = cs_pin;
      S_GOT:    addr_wren     = 1'b1;
      S_READ1:  shift_wren    = 1'b1;
      S_READ2:  miso_en       = 1'b1;
      S_WRITE2: dm_wren       = 1'b1;
      S_INC:    addr_inc      = 1'b1;
      default:  ;
    endcase
  end

  assign busy      = (state_q != S_GET);
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_spi_burst_fsm.sv
// Bench for spi_burst_fsm: random SCLK/chip-select transactions checked every cycle
// against a transaction-level event model, on a burst and a single-word instance.
module tb_spi_burst_fsm;

  localparam int ADDR_BITS = 7;
  localparam int DATA_BITS = 8;
  localparam int MAX_BURST = 4;
  localparam int BW        = $clog2(MAX_BURST);
  localparam int HDR       = ADDR_BITS + 1;
  localparam int VW        = 7 + BW;
  localparam int NMAX      = 512;
  localparam int NONE      = 1 << 30;

  logic clk, rst_n, cs_pin, sclk_rise, rw;
  logic b_shift_wren, b_reset_counter, b_addr_wren, b_dm_wren, b_miso_en, b_addr_inc, b_busy;
  logic s_shift_wren, s_reset_counter, s_addr_wren, s_dm_wren, s_miso_en, s_addr_inc, s_busy;
  logic [BW-1:0] b_burst_cnt, s_burst_cnt;

  spi_burst_fsm #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .BURST_EN(1), .MAX_BURST(MAX_BURST)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs_pin(cs_pin), .sclk_rise(sclk_rise), .rw(rw),
    .shift_wren(b_shift_wren), .reset_counter(b_reset_counter), .addr_wren(b_addr_wren),
    .dm_wren(b_dm_wren), .miso_en(b_miso_en), .addr_inc(b_addr_inc), .busy(b_busy),
    .burst_cnt(b_burst_cnt)
  );

  spi_burst_fsm #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .BURST_EN(0), .MAX_BURST(MAX_BURST)) dut_s (
    .clk(clk), .rst_n(rst_n), .cs_pin(cs_pin), .sclk_rise(sclk_rise), .rw(rw),
    .shift_wren(s_shift_wren), .reset_counter(s_reset_counter), .addr_wren(s_addr_wren),
    .dm_wren(s_dm_wren), .miso_en(s_miso_en), .addr_inc(s_addr_inc), .busy(s_busy),
    .burst_cnt(s_burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus of the current transaction plus the rise indices that end each field.
  bit cs_a [NMAX];
  bit rise_a [NMAX];
  bit rw_a [NMAX];
  int len;
  int hdr_end;
  int a_idx;
  int e_end [MAX_BURST];
  bit t_rw;

  // Expected outputs at output index p: {shift_wren, reset_counter, addr_wren, dm_wren, miso_en, addr_inc, busy, burst_cnt}
  function automatic logic [VW-1:0] model(input int p, input int nb);
    bit sw = 0, rc = 0, aw = 0, dw = 0, me = 0, ai = 0, bz = 0;
    int incs = 0;
    int start;
    if (hdr_end != NONE && p > hdr_end && p <= a_idx) begin
      bz = 1;
      aw = (p == hdr_end + 1);
      if (t_rw) begin
        sw = (p == hdr_end + 2);
        start = hdr_end + 3;
        for (int w = 0; w < nb; w++) begin
          if (e_end[w] == NONE) begin
            if (p >= start) me = 1;
            break;
          end
          if (p >= start && p <= e_end[w]) me = 1;
          if (w != nb - 1) begin
            if (p == e_end[w] + 1) ai = 1;
            if (p == e_end[w] + 2) sw = 1;
            if (p > e_end[w] + 1) incs++;
          end
          start = e_end[w] + 3;
        end
      end else begin
        for (int w = 0; w < nb; w++) begin
          if (e_end[w] == NONE) break;
          if (p == e_end[w] + 1) dw = 1;
          if (w != nb - 1) begin
            if (p == e_end[w] + 2) ai = 1;
            if (p > e_end[w] + 2) incs++;
          end
        end
      end
    end
    rc = !bz && cs_a[p-1];
    return {sw, rc, aw, dw, me, ai, bz, BW'(incs)};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build(input int n_rises, input int gmin, input int gmax, input int pre_idle, input bit rw_t);
    int i = 0;
    int g;
    int k;
    t_rw = rw_t;
    hdr_end = NONE;
    for (int w = 0; w < MAX_BURST; w++) e_end[w] = NONE;
    for (int j = 0; j < pre_idle; j++) begin
      cs_a[i] = 1; rise_a[i] = 1'($urandom_range(1, 0)); rw_a[i] = 1'($urandom_range(1, 0)); i++;
    end
    for (int r = 1; r <= n_rises; r++) begin
      g = int'($urandom_range(gmax, gmin));
      for (int j = 0; j < g; j++) begin
        cs_a[i] = 0; rise_a[i] = 0; rw_a[i] = 1'($urandom_range(1, 0)); i++;
      end
      cs_a[i] = 0; rise_a[i] = 1; rw_a[i] = 1'($urandom_range(1, 0));
      if (r == HDR) hdr_end = i;
      k = r - HDR;
      if (k > 0 && k % DATA_BITS == 0 && k / DATA_BITS <= MAX_BURST) e_end[k / DATA_BITS - 1] = i;
      i++;
    end
    g = 3 + int'($urandom_range(3, 0));
    for (int j = 0; j < g; j++) begin
      cs_a[i] = 0; rise_a[i] = 0; rw_a[i] = 1'($urandom_range(1, 0)); i++;
    end
    a_idx = i;
    for (int j = 0; j < 4; j++) begin
      cs_a[i] = 1; rise_a[i] = 1'($urandom_range(1, 0)); rw_a[i] = 1'($urandom_range(1, 0)); i++;
    end
    len = i;
    if (hdr_end != NONE) rw_a[hdr_end + 1] = rw_t;
  endtask

  task automatic run(input string name, input int stop_at);
    cs_pin = cs_a[0]; sclk_rise = rise_a[0]; rw = rw_a[0];
    for (int c = 1; c <= stop_at; c++) begin
      @(posedge clk); #1;
      check({name, "/burst"}, {b_shift_wren, b_reset_counter, b_addr_wren, b_dm_wren, b_miso_en, b_addr_inc, b_busy, b_burst_cnt}, model(c, MAX_BURST));
      check({name, "/single"}, {s_shift_wren, s_reset_counter, s_addr_wren, s_dm_wren, s_miso_en, s_addr_inc, s_busy, s_burst_cnt}, model(c, 1));
      if (c < len) begin
        cs_pin = cs_a[c]; sclk_rise = rise_a[c]; rw = rw_a[c];
      end
    end
  endtask

  logic [VW-1:0] idle_vec;
  int n_r;

  initial begin
    idle_vec = VW'(1) << (VW - 2);
    rst_n = 1'b0; cs_pin = 1'b1; sclk_rise = 1'b0; rw = 1'b0;
    #1;
    check("reset/burst", {b_shift_wren, b_reset_counter, b_addr_wren, b_dm_wren, b_miso_en, b_addr_inc, b_busy, b_burst_cnt}, idle_vec);
    check("reset/single", {s_shift_wren, s_reset_counter, s_addr_wren, s_dm_wren, s_miso_en, s_addr_inc, s_busy, s_burst_cnt}, idle_vec);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    build(0, 3, 3, 80, 1'b0);                 run("cs_high_idle", len);
    build(HDR + DATA_BITS, 3, 3, 2, 1'b0);    run("single_write", len);
    build(HDR + DATA_BITS * MAX_BURST, 3, 3, 2, 1'b1); run("read_burst", len);
    build(HDR + DATA_BITS + 3, 3, 3, 2, 1'b0); run("write_abort", len);
    build(HDR + DATA_BITS * MAX_BURST + 4, 0, 0, 2, 1'b0); run("dense_write", len);
    build(HDR + DATA_BITS * MAX_BURST + 4, 0, 0, 2, 1'b1); run("dense_read", len);

    // Asynchronous reset landing mid-READ2, between clock edges.
    build(HDR + DATA_BITS, 3, 3, 2, 1'b1);
    run("pre_reset", hdr_end + 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst/burst", VW'({b_miso_en, b_busy}), '0);
    check("async_rst/single", VW'({s_miso_en, s_busy}), '0);
    cs_pin = 1'b1; sclk_rise = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst/burst", {b_shift_wren, b_reset_counter, b_addr_wren, b_dm_wren, b_miso_en, b_addr_inc, b_busy, b_burst_cnt}, idle_vec);
    check("post_rst/single", {s_shift_wren, s_reset_counter, s_addr_wren, s_dm_wren, s_miso_en, s_addr_inc, s_busy, s_burst_cnt}, idle_vec);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1, 0) == 1) n_r = int'($urandom_range(HDR + DATA_BITS * MAX_BURST + 4, HDR + DATA_BITS));
      else n_r = int'($urandom_range(HDR + DATA_BITS * MAX_BURST + 4, 0));
      build(n_r, 0, int'($urandom_range(3, 0)), int'($urandom_range(3, 1)), 1'($urandom_range(1, 0)));
      run($sformatf("rand%0d", t), len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
